// File: rtl/ctr_updn_if.sv
// Control/status bundle for the up/down modulo counter.
// The master side drives the control inputs; the slave side is the counter.
interface ctr_updn_if #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
);
  logic               clr;
  logic               en;
  logic               up;
  logic               load;
  logic [WIDTH-1:0]   d;
  logic [WIDTH-1:0]   modulo;
  logic               sat_mode;
  logic [PRESC_W-1:0] presc;
  logic               ovf_clr;
  logic [WIDTH-1:0]   q;
  logic               tc;
  logic               ovf_sticky;

  modport master (
    output clr, en, up, load, d, modulo, sat_mode, presc, ovf_clr,
    input  q, tc, ovf_sticky
  );

  modport slave (
    input  clr, en, up, load, d, modulo, sat_mode, presc, ovf_clr,
    output q, tc, ovf_sticky
  );
endinterface

// File: rtl/ctr_updn_mod.sv
// Prescaled up/down counter with runtime modulo, wrap or saturate at the
// boundaries, a one-cycle terminal-count pulse and a sticky boundary flag.
module ctr_updn_mod #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
) (
  input logic       clk,
  input logic       rst_n,
  ctr_updn_if.slave bus
);

  logic [WIDTH-1:0]   q_p0, q_p1;
  logic [PRESC_W-1:0] pcnt_p0, pcnt_p1;
  logic               tc_p0, tc_p1;
  logic               ovf_p0, ovf_p1;
  logic               tick;
  logic               bnd;

  // Load value is clamped to the current terminal count.
  function automatic logic [WIDTH-1:0] sat_load(input logic [WIDTH-1:0] val,
                                                input logic [WIDTH-1:0] lim);
    return (val > lim) ? lim : val;
  endfunction

  // Prescaler terminal: a step happens on this same edge, no extra latency.
  always_comb tick = bus.en && (pcnt_p1 == bus.presc);

  // Next-state selection: clr > load > step > hold; tc only on a boundary step.
  always_comb begin
    q_p0    = q_p1;
    pcnt_p0 = pcnt_p1;
    bnd     = 1'b0;
    if (bus.clr) begin
      q_p0    = '0;
      pcnt_p0 = '0;
    end else if (bus.load) begin
      q_p0    = sat_load(bus.d, bus.modulo);
      pcnt_p0 = '0;
    end else if (bus.en) begin
      if (tick) begin
        pcnt_p0 = '0;
        if (q_p1 > bus.modulo) begin
          // Modulo was lowered under the count: pull back, not a boundary.
          q_p0 = bus.modulo;
        end else if (bus.up) begin
          if (q_p1 == bus.modulo) begin
            bnd  = 1'b1;
            q_p0 = bus.sat_mode ? q_p1 : '0;
          end else begin
            q_p0 = q_p1 + WIDTH'(1);
          end
        end else begin
          if (q_p1 == '0) begin
            bnd  = 1'b1;
            q_p0 = bus.sat_mode ? q_p1 : bus.modulo;
          end else begin
            q_p0 = q_p1 - WIDTH'(1);
          end
        end
      end else begin
        pcnt_p0 = pcnt_p1 + PRESC_W'(1);
      end
    end
    tc_p0  = bnd;
    // A boundary on the same edge as ovf_clr keeps the flag set.
    ovf_p0 = bnd ? 1'b1 : (bus.ovf_clr ? 1'b0 : ovf_p1);
  end

  // ---- stage boundary: registered state ----
  // Synchronous active-low reset of every state bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_p1    <= '0;
      pcnt_p1 <= '0;
      tc_p1   <= 1'b0;
      ovf_p1  <= 1'b0;
    end else begin
      q_p1    <= q_p0;
      pcnt_p1 <= pcnt_p0;
      tc_p1   <= tc_p0;
      ovf_p1  <= ovf_p0;
    end
  end

  assign bus.q          = q_p1;
  assign bus.tc         = tc_p1;
  assign bus.ovf_sticky = ovf_p1;

endmodule

// File: tb/tb_ctr_updn_mod.sv
// Scoreboard bench for ctr_updn_mod: directed scenarios plus random traffic,
// each cycle's expected outputs produced by a behavioural model.
module tb_ctr_updn_mod;

  localparam int W  = 8;
  localparam int PW = 4;

  logic clk = 1'b0;
  logic rst_n;

  ctr_updn_if #(.WIDTH(W), .PRESC_W(PW)) bus ();

  ctr_updn_mod #(.WIDTH(W), .PRESC_W(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] q;
    logic         tc;
    logic         ov;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  // Stimulus for the next edge
  bit          s_rst_n, s_clr, s_en, s_up, s_load, s_sat, s_oc;
  logic [W-1:0]  s_d, s_mod;
  logic [PW-1:0] s_presc;

  // Model state
  int m_q, m_p;
  bit m_tc, m_ov;

  task automatic expect_eq(input string nm, input logic [31:0] act,
                           input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: one clock edge worth of counter behaviour.
  function automatic void model();
    int mod;
    int pr;
    bit bnd;
    mod = int'(s_mod);
    pr  = int'(s_presc);
    bnd = 1'b0;
    if (!s_rst_n) begin
      m_q = 0; m_p = 0; m_tc = 0; m_ov = 0;
      return;
    end
    if (s_clr) begin
      m_q = 0; m_p = 0;
    end else if (s_load) begin
      m_q = (int'(s_d) < mod) ? int'(s_d) : mod;
      m_p = 0;
    end else if (s_en) begin
      if (m_p != pr) begin
        m_p = (m_p + 1) % (1 << PW);
      end else begin
        m_p = 0;
        if (m_q > mod) begin
          m_q = mod;
        end else begin
          bnd = s_up ? (m_q == mod) : (m_q == 0);
          if (!(bnd && s_sat))
            m_q = s_up ? (m_q + 1) % (mod + 1) : (m_q + mod) % (mod + 1);
        end
      end
    end
    m_tc = bnd;
    if (bnd) m_ov = 1;
    else if (s_oc) m_ov = 0;
  endfunction

  // Apply stimulus for the coming edge and queue the expected outcome.
  task automatic step_cycle();
    exp_t e;
    @(negedge clk);
    rst_n        = s_rst_n;
    bus.clr      = s_clr;
    bus.en       = s_en;
    bus.up       = s_up;
    bus.load     = s_load;
    bus.d        = s_d;
    bus.modulo   = s_mod;
    bus.sat_mode = s_sat;
    bus.presc    = s_presc;
    bus.ovf_clr  = s_oc;
    model();
    e.q  = W'(m_q);
    e.tc = m_tc;
    e.ov = m_ov;
    sbq.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step_cycle();
  endtask

  // Wait until the last queued edge has taken effect.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every edge presents new outputs; compare against the queue.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      expect_eq("sb_q", 32'(bus.q), 32'(e.q));
      expect_eq("sb_tc", 32'(bus.tc), 32'(e.tc));
      expect_eq("sb_ovf", 32'(bus.ovf_sticky), 32'(e.ov));
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    s_rst_n = 0; s_clr = 0; s_en = 1; s_up = 1; s_load = 0; s_sat = 0;
    s_oc = 0; s_d = '0; s_mod = 8'd255; s_presc = 4'd3;
    m_q = 0; m_p = 0; m_tc = 0; m_ov = 0;
    rst_n = 1'b0;
    bus.clr = 0; bus.en = 0; bus.up = 0; bus.load = 0; bus.d = '0;
    bus.modulo = '0; bus.sat_mode = 0; bus.presc = '0; bus.ovf_clr = 0;

    // Reset two cycles with en=1, presc=3
    run(2); settle();
    expect_eq("rst_q", 32'(bus.q), 0);
    expect_eq("rst_tc", 32'(bus.tc), 0);
    expect_eq("rst_ovf", 32'(bus.ovf_sticky), 0);
    s_rst_n = 1;
    run(3); settle();
    expect_eq("presc3_before", 32'(bus.q), 0);
    run(1); settle();
    expect_eq("presc3_4th", 32'(bus.q), 1);

    // modulo=9, presc=0, up, wrap
    s_clr = 1; run(1); s_clr = 0;
    s_mod = 8'd9; s_presc = 0;
    run(9); settle();
    expect_eq("wrap_q9", 32'(bus.q), 9);
    expect_eq("wrap_tc0", 32'(bus.tc), 0);
    run(1); settle();
    expect_eq("wrap_q0", 32'(bus.q), 0);
    expect_eq("wrap_tc1", 32'(bus.tc), 1);
    run(1); settle();
    expect_eq("wrap_q1", 32'(bus.q), 1);
    expect_eq("wrap_ovf", 32'(bus.ovf_sticky), 1);

    // presc=2 with en low mid-run
    s_clr = 1; run(1); s_clr = 0;
    s_mod = 8'd255; s_presc = 4'd2;
    run(4);
    s_en = 0; run(5); settle();
    expect_eq("hold_q", 32'(bus.q), 1);
    s_en = 1; run(2); settle();
    expect_eq("resume_q", 32'(bus.q), 2);

    // Saturating down-count from 2
    s_presc = 0; s_sat = 1; s_up = 0;
    s_load = 1; s_d = 8'd2; run(1); s_load = 0;
    run(2); settle();
    expect_eq("satdn_q0", 32'(bus.q), 0);
    expect_eq("satdn_tc0", 32'(bus.tc), 0);
    run(2); settle();
    expect_eq("satdn_hold", 32'(bus.q), 0);
    expect_eq("satdn_tc1", 32'(bus.tc), 1);

    // Load clamp, load+clr, modulo lowered under count
    s_sat = 0; s_up = 1; s_en = 0; s_mod = 8'd100;
    s_load = 1; s_d = 8'd200; run(1); settle();
    expect_eq("load_clamp", 32'(bus.q), 100);
    s_clr = 1; run(1); s_clr = 0; settle();
    expect_eq("load_clr", 32'(bus.q), 0);
    s_d = 8'd100; run(1); s_load = 0;
    s_mod = 8'd50; s_en = 1; run(1); settle();
    expect_eq("lower_q", 32'(bus.q), 50);
    expect_eq("lower_tc", 32'(bus.tc), 0);

    // ovf_clr vs boundary on the same edge
    s_en = 0; s_oc = 1; run(1); settle();
    expect_eq("ovfclr_alone0", 32'(bus.ovf_sticky), 0);
    s_en = 1; run(1); settle();
    expect_eq("ovf_set_wins", 32'(bus.ovf_sticky), 1);
    expect_eq("ovf_wrap_q", 32'(bus.q), 0);
    s_en = 0; run(1); settle();
    expect_eq("ovfclr_next", 32'(bus.ovf_sticky), 0);
    s_oc = 0;

    // Single-cycle reset mid-count, presc=1
    s_en = 1; s_presc = 4'd1; s_mod = 8'd200; run(6);
    s_rst_n = 0; run(1); s_rst_n = 1; settle();
    expect_eq("midrst_q", 32'(bus.q), 0);
    run(2); settle();
    expect_eq("midrst_resume", 32'(bus.q), 1);

    // modulo=0: every step is a boundary
    s_presc = 0; s_mod = 0; s_clr = 1; run(1); s_clr = 0;
    run(2); settle();
    expect_eq("mod0_q", 32'(bus.q), 0);
    expect_eq("mod0_tc", 32'(bus.tc), 1);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      s_rst_n = ($urandom_range(0, 63) != 0);
      s_clr   = ($urandom_range(0, 31) == 0);
      s_load  = ($urandom_range(0, 15) == 0);
      s_en    = ($urandom_range(0, 3) != 0);
      s_oc    = ($urandom_range(0, 7) == 0);
      s_d     = W'($urandom_range(0, 255));
      if ($urandom_range(0, 19) == 0)
        s_mod = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255))
                                            : W'($urandom_range(0, 12));
      if ($urandom_range(0, 9) == 0) s_up = ~s_up;
      if ($urandom_range(0, 29) == 0) s_sat = ~s_sat;
      if ($urandom_range(0, 49) == 0) s_presc = PW'($urandom_range(0, 3));
      step_cycle();
    end
    settle();
    settle();
    expect_eq("sb_drained", 32'(sbq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
